// File: rtl/instr_mem_if.sv
// +--------------------------------------------------------------------------+
// | instr_mem_if : fetch and program-load signal bundle for instr_mem_loadable|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface instr_mem_if #(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_BYTES = 2
);
    localparam int IW = 8 * INSTR_BYTES;

    logic                  fetch_req;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  fetch_valid;
    logic [IW-1:0]         fetch_data;
    logic                  fetch_fault;

    logic                  load_start;
    logic [ADDR_WIDTH-1:0] load_base;
    logic                  load_valid;
    logic [7:0]            load_byte;
    logic                  load_last;
    logic                  load_ready;
    logic [ADDR_WIDTH:0]   load_count;
    logic [1:0]            mem_state;

    modport master (
        output fetch_req, fetch_addr,
        output load_start, load_base, load_valid, load_byte, load_last,
        input  fetch_valid, fetch_data, fetch_fault,
        input  load_ready, load_count, mem_state
    );

    modport slave (
        input  fetch_req, fetch_addr,
        input  load_start, load_base, load_valid, load_byte, load_last,
        output fetch_valid, fetch_data, fetch_fault,
        output load_ready, load_count, mem_state
    );
endinterface

`default_nettype wire

// File: rtl/instr_mem_loadable.sv
// +--------------------------------------------------------------------------+
// | instr_mem_loadable : byte-addressed instruction memory, registered fetch  |
// | port and byte-serial loader that gates fetches until a load completes.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module instr_mem_loadable #(
    parameter int                       ADDR_WIDTH  = 8,
    parameter int                       INSTR_BYTES = 2,
    parameter logic [8*INSTR_BYTES-1:0] HALT_WORD   = '0
) (
    input  wire logic       clk_i,
    input  wire logic       reset_ni,
    instr_mem_if.slave      bus
);
    localparam int                  IW         = 8 * INSTR_BYTES;
    localparam int                  DEPTH      = 2 ** ADDR_WIDTH;
    localparam int                  ALIGN_BITS = $clog2(INSTR_BYTES);
    localparam logic [ADDR_WIDTH:0] COUNT_MAX  = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_LOADING = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  fetch_valid_q, fetch_valid_d;
    logic                  fetch_fault_q, fetch_fault_d;
    logic [IW-1:0]         fetch_data_q, fetch_data_d;
    logic                  mem_we;
    logic                  misaligned;
    logic [IW-1:0]         rd_word;

    // Array is deliberately left out of reset: contents survive an aborted load.
    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[ptr_q] <= bus.load_byte;
        end
    end

    for (genvar b = 0; b < INSTR_BYTES; b++) begin : g_rd_byte
        logic [ADDR_WIDTH-1:0] byte_addr;
        assign byte_addr            = bus.fetch_addr + ADDR_WIDTH'(b);
        assign rd_word[8*b +: 8]    = mem_q[byte_addr];
    end

    if (INSTR_BYTES == 1) begin : g_align_none
        assign misaligned = 1'b0;
    end else begin : g_align_chk
        assign misaligned = |bus.fetch_addr[ALIGN_BITS-1:0];
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q       <= ST_EMPTY;
            ptr_q         <= '0;
            count_q       <= '0;
            fetch_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
            fetch_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            count_q       <= count_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_fault_q <= fetch_fault_d;
            fetch_data_q  <= fetch_data_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        count_d       = count_q;
        mem_we        = 1'b0;
        fetch_valid_d = 1'b0;
        fetch_fault_d = 1'b0;
        fetch_data_d  = fetch_data_q;

        if (bus.load_start) begin
            state_d = ST_LOADING;
            ptr_d   = bus.load_base;
            count_d = '0;
        end else if (state_q == ST_LOADING && bus.load_valid) begin
            mem_we = 1'b1;
            ptr_d  = ptr_q + 1'b1;
            if (count_q != COUNT_MAX) begin
                count_d = count_q + 1'b1;
            end
            if (bus.load_last) begin
                state_d = ST_RUN;
            end
        end

        // Fetch sees the pre-edge state, so a LOADING array is never read.
        if (bus.fetch_req) begin
            fetch_valid_d = 1'b1;
            if (state_q != ST_RUN || misaligned) begin
                fetch_fault_d = 1'b1;
                fetch_data_d  = HALT_WORD;
            end else begin
                fetch_data_d  = rd_word;
            end
        end
    end

    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_fault = fetch_fault_q;
    assign bus.fetch_data  = fetch_data_q;
    assign bus.load_ready  = (state_q == ST_LOADING);
    assign bus.load_count  = count_q;
    assign bus.mem_state   = state_q;
endmodule

`default_nettype wire

// File: tb/tb_instr_mem_loadable.sv
// +--------------------------------------------------------------------------+
// | tb_instr_mem_loadable : directed self-checking bench for instr_mem_loadable|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_instr_mem_loadable;
    localparam int          ADDR_WIDTH  = 8;
    localparam int          INSTR_BYTES = 2;
    localparam logic [15:0] HALT        = 16'hDEAD;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_bad;

    instr_mem_if #(.ADDR_WIDTH(ADDR_WIDTH), .INSTR_BYTES(INSTR_BYTES)) bus ();

    instr_mem_loadable #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INSTR_BYTES(INSTR_BYTES),
        .HALT_WORD  (HALT)
    ) dut (
        .clk_i   (clk),
        .reset_ni(reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [7:0] addr);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = addr;
        tick();
        bus.fetch_req  = 1'b0;
    endtask

    task automatic start_load(input logic [7:0] base);
        bus.load_start = 1'b1;
        bus.load_base  = base;
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        bus.load_valid = 1'b1;
        bus.load_byte  = b;
        bus.load_last  = last;
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic check_fetch(input string tag, input logic fault, input logic [15:0] data);
        check({tag, ".valid"}, 32'(bus.fetch_valid), 32'd1);
        check({tag, ".fault"}, 32'(bus.fetch_fault), 32'(fault));
        check({tag, ".data"},  32'(bus.fetch_data),  32'(data));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset_n        = 1'b0;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        bus.load_start = 1'b0;
        bus.load_base  = '0;
        bus.load_valid = 1'b0;
        bus.load_byte  = '0;
        bus.load_last  = 1'b0;
        #22 reset_n = 1'b1;
        tick();

        // T1: reset state, fetch in EMPTY faults
        check("rst.state", 32'(bus.mem_state), 32'd0);
        check("rst.ready", 32'(bus.load_ready), 32'd0);
        check("rst.count", 32'(bus.load_count), 32'd0);
        check("rst.valid", 32'(bus.fetch_valid), 32'd0);
        check("rst.data",  32'(bus.fetch_data), 32'd0);
        fetch(8'h00);
        check_fetch("t1.empty", 1'b1, HALT);

        // T2: basic load and aligned fetches
        start_load(8'h00);
        check("t2.state_ld", 32'(bus.mem_state), 32'd1);
        check("t2.ready",    32'(bus.load_ready), 32'd1);
        send(8'h21, 1'b0);
        send(8'hFE, 1'b0);
        send(8'h22, 1'b0);
        send(8'hFB, 1'b1);
        check("t2.state_run", 32'(bus.mem_state), 32'd2);
        check("t2.count",     32'(bus.load_count), 32'd4);
        check("t2.ready_off", 32'(bus.load_ready), 32'd0);
        fetch(8'h00);
        check_fetch("t2.f00", 1'b0, 16'hFE21);
        fetch(8'h02);
        check_fetch("t2.f02", 1'b0, 16'hFB22);

        // T3: misaligned fetch, then idle holds data
        fetch(8'h01);
        check_fetch("t3.f01", 1'b1, HALT);
        tick();
        check("t3.idle_valid", 32'(bus.fetch_valid), 32'd0);
        check("t3.idle_fault", 32'(bus.fetch_fault), 32'd0);
        check("t3.idle_data",  32'(bus.fetch_data),  32'(HALT));

        // T4: fetch concurrent with load_start reads old contents; wrap-around load
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 8'h00;
        start_load(8'hFE);
        bus.fetch_req  = 1'b0;
        check_fetch("t4.concurrent", 1'b0, 16'hFE21);
        check("t4.state_ld", 32'(bus.mem_state), 32'd1);
        send(8'h77, 1'b0);
        send(8'h66, 1'b1);
        start_load(8'hFF);
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        check("t4.count", 32'(bus.load_count), 32'd2);
        fetch(8'hFE);
        check_fetch("t4.fFE", 1'b0, 16'hAA77);
        fetch(8'h00);
        check_fetch("t4.f00", 1'b0, 16'hFEBB);

        // T5: restart during LOADING drops the coincident byte
        start_load(8'h20);
        fetch(8'h20);
        check_fetch("t5.f_loading", 1'b1, HALT);
        send(8'h55, 1'b0);
        check("t5.count1", 32'(bus.load_count), 32'd1);
        bus.load_valid = 1'b1;
        bus.load_byte  = 8'h99;
        start_load(8'h10);
        bus.load_valid = 1'b0;
        check("t5.count_restart", 32'(bus.load_count), 32'd0);
        check("t5.state",         32'(bus.mem_state), 32'd1);
        send(8'h31, 1'b0);
        send(8'h32, 1'b1);
        check("t5.count2", 32'(bus.load_count), 32'd2);
        fetch(8'h10);
        check_fetch("t5.f10", 1'b0, 16'h3231);

        // T6: asynchronous reset mid-load
        start_load(8'h40);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check("t6.state", 32'(bus.mem_state), 32'd0);
        check("t6.ready", 32'(bus.load_ready), 32'd0);
        check("t6.count", 32'(bus.load_count), 32'd0);
        check("t6.data",  32'(bus.fetch_data), 32'd0);
        check("t6.fault", 32'(bus.fetch_fault), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        fetch(8'h40);
        check_fetch("t6.f_empty", 1'b1, HALT);
        start_load(8'h40);
        send(8'h0A, 1'b0);
        send(8'h0B, 1'b1);
        check("t6.state_run", 32'(bus.mem_state), 32'd2);
        fetch(8'h40);
        check_fetch("t6.f40", 1'b0, 16'h0B0A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
